multi_cycle_control: RTL and testbench
======================================

// Module: multi_cycle_control
// PURPOSE
//  FSM controller that sequences the shared CPU datapath over several cycles per instruction: IF, ID, EX, MEM, WB.
//  It replaces per-instruction single-cycle control. It emits the existing control vectors plus per-phase write enables.
//  It waits on instruction-memory and data-memory ready handshakes.
//  It sits between the instruction register, register file, ALU, NPC unit and the memories.
// PARAMETERS
//  STALL_LIMIT  15  max cycles to wait for imem_ready/dmem_ready before bus_err; 0 = wait forever
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1   rising-edge clock (single domain)
//  rst          in   1   asynchronous, active-high reset
//  opcode       in   6   IR[31:26]; stable from ID onward
//  func         in   6   IR[5:0]
//  zero         in   1   ALU zero flag, valid in EX
//  imem_ready   in   1   instruction word valid this cycle
//  dmem_ready   in   1   data access complete this cycle
//  pc_write     out  1   load PC from NPC this cycle
//  ir_write     out  1   latch instruction word into IR
//  reg_write    out  1   register-file write strobe (WB only)
//  mem_read     out  1   data-memory read request (MEM, lw)
//  mem_write    out  1   data-memory write request (MEM, sw)
//  alu_op       out  `ALU_OP_LENGTH   ALU function; same encoding as existing ALU
//  alu_src      out  1   0 = rt, 1 = extended immediate
//  reg_dst      out  2   `REG_DST_* select
//  reg_src      out  `REG_SRC_LENGTH  `REG_SRC_* writeback select
//  ext_op       out  `EXT_OP_LENGTH   `EXT_OP_* immediate extension
//  npc_op       out  `NPC_OP_LENGTH   `NPC_OP_* next-PC select, qualified by pc_write
//  state        out  3   current state (debug)
//  retire       out  1   one-cycle pulse when an instruction completes
//  retire_cnt   out  CNT_W  count of retired instructions; wraps at 2^CNT_W
//  illegal      out  1   one-cycle pulse in ID on an unsupported opcode/func
//  bus_err      out  1   one-cycle pulse on stall timeout
// BEHAVIOUR
//  Reset: state=IF; all strobes, retire, illegal and bus_err =0; retire_cnt=0; stall counter=0. Takes effect immediately, mid-instruction included.
//  Decoded control vectors are combinational from opcode/func, with the same encodings as the single-cycle set.
//  Strobes are combinational from state, and from ready where stated.
//  IF:  hold until imem_ready. Then ir_write=1, next=ID. No PC update in IF.
//  ID:  legal instruction -> EX, except:
//   - j: pc_write=1, npc_op=JUMP, retire, next=IF.
//   - jal: next=WB.
//   - illegal: illegal=1, pc_write=1, npc_op=NEXT (skip), no retire, next=IF.
//  EX:
//   - beq: pc_write=1; npc_op=OFFSET if zero, else NEXT; retire; next=IF.
//   - lw/sw: next=MEM.
//   - others: next=WB.
//  MEM: assert mem_read (lw) or mem_write (sw) every cycle until dmem_ready.
//   - sw on dmem_ready: pc_write=1 (NEXT), retire, next=IF.
//   - lw on dmem_ready: next=WB.
//  WB:  reg_write=1, pc_write=1, npc_op=NEXT (JUMP for jal), retire, next=IF.
//  Stall counter: increments each waiting cycle in IF/MEM and clears on ready or state change.
//   - When it reaches STALL_LIMIT (STALL_LIMIT!=0): bus_err=1, strobes drop, next=IF, PC not advanced, no retire.
//   - ready arriving in the same cycle as the limit: ready wins, no bus_err.
//  Latency (zero wait states): j 2; beq 3; R/imm 4; sw 4; lw 5 cycles.
//  reg_write and mem_write are never high outside WB/MEM. pc_write is high at most once per instruction.
//  retire_cnt increments on retire and wraps to 0 after all-ones.
// STRUCTURE
//  Shared header (instruction_head.v) gains `MC_ST_IF=0, ID=1, EX=2, MEM=3, WB=4 and `MC_STATE_LENGTH=3.
//  Opcode, func and the ALU/REG/EXT/NPC encodings stay in that header.
//  Sub-module mc_inst_decode: combinational opcode/func -> instruction class (rtype, imm, lw, sw, beq, j, jal, illegal) plus the control vectors.
//  FSM, stall counter and retire counter live in the top module.
// TESTING
//  1) rst mid-MEM of sw -> same cycle: mem_write=0, state=IF; retire_cnt=0 after release.
//  2) addu, imem/dmem ready tied 1 -> IF,ID,EX,WB. reg_write only in cycle 4 with reg_dst=RD, reg_src=ALU. retire_cnt=1.
//  3) beq with zero=1 then zero=0 -> EX has pc_write=1 with npc_op=OFFSET, then NEXT. reg_write never 1.
//  4) lw with dmem_ready delayed 3 cycles -> mem_read held 4 cycles; WB reg_src=MEM, reg_dst=RT; 8 cycles total.
//  5) STALL_LIMIT=4, imem_ready=0 -> bus_err pulse after 4 waiting cycles, no pc_write. Ready on the limit cycle -> no bus_err.
//  6) opcode 6'h3F -> illegal pulse in ID, pc_write=1 (NEXT), retire_cnt unchanged. retire_cnt preset to all-ones + jal -> wraps to 0, WB reg_dst=REG_31.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes/funcs and
// the datapath control-vector encodings used by the ALU, register file, extender and NPC unit.
package multi_cycle_control_pkg;

  localparam int MC_STATE_LENGTH = 3;
  localparam logic [MC_STATE_LENGTH-1:0] MC_ST_IF  = 3'd0;
  localparam logic [MC_STATE_LENGTH-1:0] MC_ST_ID  = 3'd1;
  localparam logic [MC_STATE_LENGTH-1:0] MC_ST_EX  = 3'd2;
  localparam logic [MC_STATE_LENGTH-1:0] MC_ST_MEM = 3'd3;
  localparam logic [MC_STATE_LENGTH-1:0] MC_ST_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;

  localparam int ALU_OP_LENGTH  = 3;
  localparam int REG_DST_LENGTH = 2;
  localparam int REG_SRC_LENGTH = 2;
  localparam int EXT_OP_LENGTH  = 2;
  localparam int NPC_OP_LENGTH  = 2;

  localparam logic [ALU_OP_LENGTH-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_SLT = 3'd4;
  localparam logic [ALU_OP_LENGTH-1:0] ALU_LUI = 3'd5;

  localparam logic [REG_DST_LENGTH-1:0] REG_DST_RT     = 2'd0;
  localparam logic [REG_DST_LENGTH-1:0] REG_DST_RD     = 2'd1;
  localparam logic [REG_DST_LENGTH-1:0] REG_DST_REG_31 = 2'd2;

  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_ALU = 2'd0;
  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM = 2'd1;
  localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_PC  = 2'd2;

  localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_ZERO = 2'd0;
  localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_SIGN = 2'd1;
  localparam logic [EXT_OP_LENGTH-1:0] EXT_OP_HIGH = 2'd2;

  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_NEXT   = 2'd0;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JUMP   = 2'd1;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_OFFSET = 2'd2;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_IMM     = 3'd1,
    CLS_LW      = 3'd2,
    CLS_SW      = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_J       = 3'd5,
    CLS_JAL     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } inst_class_e;

endpackage

// File: rtl/mc_inst_decode.sv
// Combinational instruction decode: opcode/func to instruction class plus the
// datapath control vectors, encoded exactly as in the single-cycle control set.
module mc_inst_decode
  import multi_cycle_control_pkg::*;
(
  input  logic [5:0]                opcode,
  input  logic [5:0]                func,
  output logic [2:0]                inst_class,
  output logic [ALU_OP_LENGTH-1:0]  alu_op,
  output logic                      alu_src,
  output logic [REG_DST_LENGTH-1:0] reg_dst,
  output logic [REG_SRC_LENGTH-1:0] reg_src,
  output logic [EXT_OP_LENGTH-1:0]  ext_op
);

  inst_class_e cls;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    cls     = CLS_ILLEGAL;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    reg_dst = REG_DST_RT;
    reg_src = REG_SRC_ALU;
    ext_op  = EXT_OP_ZERO;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = REG_DST_RD;
        cls     = CLS_RTYPE;
        case (func)
          FUNC_ADDU: alu_op = ALU_ADD;
          FUNC_SUBU: alu_op = ALU_SUB;
          FUNC_AND:  alu_op = ALU_AND;
          FUNC_OR:   alu_op = ALU_OR;
          FUNC_SLT:  alu_op = ALU_SLT;
          default:   cls    = CLS_ILLEGAL;
        endcase
      end
      OP_ADDIU: begin
        cls     = CLS_IMM;
        alu_src = 1'b1;
        ext_op  = EXT_OP_SIGN;
      end
      OP_ORI: begin
        cls     = CLS_IMM;
        alu_op  = ALU_OR;
        alu_src = 1'b1;
      end
      OP_LUI: begin
        cls     = CLS_IMM;
        alu_op  = ALU_LUI;
        alu_src = 1'b1;
        ext_op  = EXT_OP_HIGH;
      end
      OP_LW: begin
        cls     = CLS_LW;
        alu_src = 1'b1;
        ext_op  = EXT_OP_SIGN;
        reg_src = REG_SRC_MEM;
      end
      OP_SW: begin
        cls     = CLS_SW;
        alu_src = 1'b1;
        ext_op  = EXT_OP_SIGN;
      end
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
        ext_op = EXT_OP_SIGN;
      end
      OP_J:   cls = CLS_J;
      OP_JAL: begin
        cls     = CLS_JAL;
        reg_dst = REG_DST_REG_31;
        reg_src = REG_SRC_PC;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign inst_class = cls;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU controller: IF/ID/EX/MEM/WB sequencing with memory-ready
// handshakes, stall timeout (bus_err) and a retired-instruction counter.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 opcode,
  input  logic [5:0]                 func,
  input  logic                       zero,
  input  logic                       imem_ready,
  input  logic                       dmem_ready,
  output logic                       pc_write,
  output logic                       ir_write,
  output logic                       reg_write,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ALU_OP_LENGTH-1:0]   alu_op,
  output logic                       alu_src,
  output logic [REG_DST_LENGTH-1:0]  reg_dst,
  output logic [REG_SRC_LENGTH-1:0]  reg_src,
  output logic [EXT_OP_LENGTH-1:0]   ext_op,
  output logic [NPC_OP_LENGTH-1:0]   npc_op,
  output logic [MC_STATE_LENGTH-1:0] state,
  output logic                       retire,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic                       illegal,
  output logic                       bus_err
);

  localparam int STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [2:0]                 inst_class;
  logic [MC_STATE_LENGTH-1:0] state_q, state_d;
  logic [STALL_W-1:0]         stall_cnt;
  logic                       stall_inc;
  logic                       timeout;
  logic [CNT_W-1:0]           cnt_q;

  mc_inst_decode u_decode (
    .opcode     (opcode),
    .func       (func),
    .inst_class (inst_class),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .reg_src    (reg_src),
    .ext_op     (ext_op)
  );

  // The limit cycle is the one where the counter already holds STALL_LIMIT; ready still wins there.
  assign timeout = (STALL_LIMIT != 0) && (stall_cnt == STALL_MAX);

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    npc_op    = NPC_OP_NEXT;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    stall_inc = 1'b0;
    // Strobes are gated by reset so they drop in the same cycle reset is applied.
    if (!rst) begin
      case (state_q)
        MC_ST_IF: begin
          if (imem_ready) begin
            ir_write = 1'b1;
            state_d  = MC_ST_ID;
          end else if (timeout) begin
            bus_err = 1'b1;
          end else begin
            stall_inc = (STALL_LIMIT != 0);
          end
        end
        MC_ST_ID: begin
          case (inst_class)
            CLS_J: begin
              pc_write = 1'b1;
              npc_op   = NPC_OP_JUMP;
              retire   = 1'b1;
              state_d  = MC_ST_IF;
            end
            CLS_JAL: state_d = MC_ST_WB;
            CLS_ILLEGAL: begin
              illegal  = 1'b1;
              pc_write = 1'b1;
              state_d  = MC_ST_IF;
            end
            default: state_d = MC_ST_EX;
          endcase
        end
        MC_ST_EX: begin
          case (inst_class)
            CLS_BEQ: begin
              pc_write = 1'b1;
              npc_op   = zero ? NPC_OP_OFFSET : NPC_OP_NEXT;
              retire   = 1'b1;
              state_d  = MC_ST_IF;
            end
            CLS_LW, CLS_SW: state_d = MC_ST_MEM;
            default:        state_d = MC_ST_WB;
          endcase
        end
        MC_ST_MEM: begin
          if (dmem_ready || !timeout) begin
            mem_read  = (inst_class == CLS_LW);
            mem_write = (inst_class == CLS_SW);
          end
          if (dmem_ready) begin
            if (inst_class == CLS_SW) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = MC_ST_IF;
            end else begin
              state_d = MC_ST_WB;
            end
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = MC_ST_IF;
          end else begin
            stall_inc = (STALL_LIMIT != 0);
          end
        end
        MC_ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          npc_op    = (inst_class == CLS_JAL) ? NPC_OP_JUMP : NPC_OP_NEXT;
          retire    = 1'b1;
          state_d   = MC_ST_IF;
        end
        default: state_d = MC_ST_IF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MC_ST_IF;
      stall_cnt <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      stall_cnt <= stall_inc ? stall_cnt + 1'b1 : '0;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state      = state_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Table-driven bench for multi_cycle_control: per-cycle vectors go through a
// scoreboard queue, plus hand-written reset and decode checks.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, func;
  logic zero, imem_ready, dmem_ready;
  logic pc_write, ir_write, reg_write, mem_read, mem_write;
  logic [ALU_OP_LENGTH-1:0]   alu_op;
  logic                       alu_src;
  logic [REG_DST_LENGTH-1:0]  reg_dst;
  logic [REG_SRC_LENGTH-1:0]  reg_src;
  logic [EXT_OP_LENGTH-1:0]   ext_op;
  logic [NPC_OP_LENGTH-1:0]   npc_op;
  logic [MC_STATE_LENGTH-1:0] state;
  logic retire, illegal, bus_err;
  logic [CNT_W-1:0] retire_cnt;

  multi_cycle_control #(.STALL_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .reg_src    (reg_src),
    .ext_op     (ext_op),
    .npc_op     (npc_op),
    .state      (state),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Strobe order: {pc_write, ir_write, reg_write, mem_read, mem_write, retire, illegal, bus_err}
  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_IR   = 8'b0100_0000;
  localparam logic [7:0] S_PCR  = 8'b1000_0100;
  localparam logic [7:0] S_WB   = 8'b1010_0100;
  localparam logic [7:0] S_MR   = 8'b0001_0000;
  localparam logic [7:0] S_MW   = 8'b0000_1000;
  localparam logic [7:0] S_SW   = 8'b1000_1100;
  localparam logic [7:0] S_ILL  = 8'b1000_0010;
  localparam logic [7:0] S_BERR = 8'b0000_0001;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ir;
    logic       dr;
    logic [2:0] st;
    logic [7:0] strb;
    logic [1:0] npc;
    logic       chk;
    logic       as;
    logic [1:0] rd;
    logic [1:0] rs;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_row(string n, logic [5:0] op, logic [5:0] fn, logic z,
                                  logic ir, logic dr, logic [2:0] st, logic [7:0] strb,
                                  logic [1:0] npc = NPC_OP_NEXT, logic chk = 1'b0,
                                  logic as = 1'b0, logic [1:0] rd = 2'd0, logic [1:0] rs = 2'd0);
    vec_t v;
    v.name = n; v.op = op; v.fn = fn; v.z = z; v.ir = ir; v.dr = dr;
    v.st = st; v.strb = strb; v.npc = npc; v.chk = chk; v.as = as; v.rd = rd; v.rs = rs;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_t e;
    logic [7:0] act_strb;

    // addu, zero wait states: IF, ID, EX, WB
    add_row("addu_if", OP_RTYPE, FUNC_ADDU, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("addu_id", OP_RTYPE, FUNC_ADDU, 0, 1, 1, MC_ST_ID, S_NONE);
    add_row("addu_ex", OP_RTYPE, FUNC_ADDU, 0, 1, 1, MC_ST_EX, S_NONE);
    add_row("addu_wb", OP_RTYPE, FUNC_ADDU, 0, 1, 1, MC_ST_WB, S_WB, NPC_OP_NEXT, 1, 0, REG_DST_RD, REG_SRC_ALU);
    // beq taken then not taken
    add_row("beq1_if", OP_BEQ, 6'h0, 1, 1, 1, MC_ST_IF, S_IR);
    add_row("beq1_id", OP_BEQ, 6'h0, 1, 1, 1, MC_ST_ID, S_NONE);
    add_row("beq1_ex", OP_BEQ, 6'h0, 1, 1, 1, MC_ST_EX, S_PCR, NPC_OP_OFFSET);
    add_row("beq0_if", OP_BEQ, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("beq0_id", OP_BEQ, 6'h0, 0, 1, 1, MC_ST_ID, S_NONE);
    add_row("beq0_ex", OP_BEQ, 6'h0, 0, 1, 1, MC_ST_EX, S_PCR, NPC_OP_NEXT);
    // lw with dmem_ready three cycles late
    add_row("lw_if", OP_LW, 6'h0, 0, 1, 0, MC_ST_IF, S_IR);
    add_row("lw_id", OP_LW, 6'h0, 0, 1, 0, MC_ST_ID, S_NONE);
    add_row("lw_ex", OP_LW, 6'h0, 0, 1, 0, MC_ST_EX, S_NONE);
    for (int k = 0; k < 3; k++) add_row("lw_memwait", OP_LW, 6'h0, 0, 1, 0, MC_ST_MEM, S_MR);
    add_row("lw_memdone", OP_LW, 6'h0, 0, 1, 1, MC_ST_MEM, S_MR);
    add_row("lw_wb", OP_LW, 6'h0, 0, 1, 1, MC_ST_WB, S_WB, NPC_OP_NEXT, 1, 1, REG_DST_RT, REG_SRC_MEM);
    // sw, zero wait states
    add_row("sw_if", OP_SW, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("sw_id", OP_SW, 6'h0, 0, 1, 1, MC_ST_ID, S_NONE);
    add_row("sw_ex", OP_SW, 6'h0, 0, 1, 1, MC_ST_EX, S_NONE);
    add_row("sw_mem", OP_SW, 6'h0, 0, 1, 1, MC_ST_MEM, S_SW, NPC_OP_NEXT);
    // j
    add_row("j_if", OP_J, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("j_id", OP_J, 6'h0, 0, 1, 1, MC_ST_ID, S_PCR, NPC_OP_JUMP);
    // illegal opcode and illegal R-type func
    add_row("ill_op_if", 6'h3F, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("ill_op_id", 6'h3F, 6'h0, 0, 1, 1, MC_ST_ID, S_ILL, NPC_OP_NEXT);
    add_row("ill_fn_if", OP_RTYPE, 6'h3F, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("ill_fn_id", OP_RTYPE, 6'h3F, 0, 1, 1, MC_ST_ID, S_ILL, NPC_OP_NEXT);
    // IF stall timeout, then ready on the limit cycle
    for (int k = 0; k < 4; k++) add_row("if_wait", OP_ADDIU, 6'h0, 0, 0, 1, MC_ST_IF, S_NONE);
    add_row("if_timeout", OP_ADDIU, 6'h0, 0, 0, 1, MC_ST_IF, S_BERR);
    for (int k = 0; k < 4; k++) add_row("if_wait2", OP_ADDIU, 6'h0, 0, 0, 1, MC_ST_IF, S_NONE);
    add_row("if_ready_at_limit", OP_ADDIU, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("addiu_id", OP_ADDIU, 6'h0, 0, 1, 1, MC_ST_ID, S_NONE);
    add_row("addiu_ex", OP_ADDIU, 6'h0, 0, 1, 1, MC_ST_EX, S_NONE);
    add_row("addiu_wb", OP_ADDIU, 6'h0, 0, 1, 1, MC_ST_WB, S_WB, NPC_OP_NEXT, 1, 1, REG_DST_RT, REG_SRC_ALU);
    // MEM stall timeout on sw
    add_row("swto_if", OP_SW, 6'h0, 0, 1, 0, MC_ST_IF, S_IR);
    add_row("swto_id", OP_SW, 6'h0, 0, 1, 0, MC_ST_ID, S_NONE);
    add_row("swto_ex", OP_SW, 6'h0, 0, 1, 0, MC_ST_EX, S_NONE);
    for (int k = 0; k < 4; k++) add_row("swto_wait", OP_SW, 6'h0, 0, 1, 0, MC_ST_MEM, S_MW);
    add_row("swto_timeout", OP_SW, 6'h0, 0, 1, 0, MC_ST_MEM, S_BERR);
    // fill the counter to all-ones, then jal wraps it
    for (int k = 0; k < 8; k++) begin
      add_row("jfill_if", OP_J, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
      add_row("jfill_id", OP_J, 6'h0, 0, 1, 1, MC_ST_ID, S_PCR, NPC_OP_JUMP);
    end
    add_row("jal_if", OP_JAL, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("jal_id", OP_JAL, 6'h0, 0, 1, 1, MC_ST_ID, S_NONE);
    add_row("jal_wb", OP_JAL, 6'h0, 0, 1, 1, MC_ST_WB, S_WB, NPC_OP_JUMP, 1, 0, REG_DST_REG_31, REG_SRC_PC);
    add_row("jwrap_if", OP_J, 6'h0, 0, 1, 1, MC_ST_IF, S_IR);
    add_row("jwrap_id", OP_J, 6'h0, 0, 1, 1, MC_ST_ID, S_PCR, NPC_OP_JUMP);

    // Reset state with ready inputs high: strobes must still be low.
    rst = 1'b1; opcode = OP_ADDIU; func = 6'h0; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    exp_cnt = '0;
    #3;
    check("reset_state", 32'(state), 32'(MC_ST_IF));
    check("reset_ir_write", 32'(ir_write), 32'd0);
    check("reset_retire_cnt", 32'(retire_cnt), 32'd0);
    check("dec_addiu_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("dec_addiu_ext_op", 32'(ext_op), 32'(EXT_OP_SIGN));
    opcode = OP_LUI;
    #1;
    check("dec_lui_alu_op", 32'(alu_op), 32'(ALU_LUI));
    check("dec_lui_ext_op", 32'(ext_op), 32'(EXT_OP_HIGH));
    check("dec_lui_alu_src", 32'(alu_src), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].op; func = tbl[i].fn; zero = tbl[i].z;
      imem_ready = tbl[i].ir; dmem_ready = tbl[i].dr;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      act_strb = {pc_write, ir_write, reg_write, mem_read, mem_write, retire, illegal, bus_err};
      check({e.name, " state"}, 32'(state), 32'(e.st));
      check({e.name, " strobes"}, 32'(act_strb), 32'(e.strb));
      check({e.name, " retire_cnt"}, 32'(retire_cnt), 32'(exp_cnt));
      if (e.strb[7]) check({e.name, " npc_op"}, 32'(npc_op), 32'(e.npc));
      if (e.chk) begin
        check({e.name, " reg_dst"}, 32'(reg_dst), 32'(e.rd));
        check({e.name, " reg_src"}, 32'(reg_src), 32'(e.rs));
        check({e.name, " alu_src"}, 32'(alu_src), 32'(e.as));
      end
      if (e.strb[2]) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk); #1;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of an sw MEM wait
    opcode = OP_SW; func = 6'h0; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rstmem_pre_state", 32'(state), 32'(MC_ST_MEM));
    check("rstmem_pre_mem_write", 32'(mem_write), 32'd1);
    check("rstmem_pre_cnt", 32'(retire_cnt), 32'(exp_cnt));
    #2 rst = 1'b1;
    #1;
    check("rstmem_mem_write", 32'(mem_write), 32'd0);
    check("rstmem_state", 32'(state), 32'(MC_ST_IF));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmem_retire_cnt", 32'(retire_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
